// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between fetch and decode.
//
// Captures {pc, instr} pairs from the fetch stage and hands them to decode
// in strict FIFO order under a valid/ready handshake. When every entry is
// occupied, f_stall holds the PC register so the same pair is re-presented.
// A branch/jump redirect (flush) discards everything queued plus the pair
// arriving in that cycle.
//
// Optional build macro: FETCHQ_BYPASS_EN
//   Defined   : an empty queue forwards f_pc/f_instr straight to decode, and
//               the pair is consumed without being stored when d_ready=1.
//   Undefined : no combinational f_* to d_* path; latency is one cycle.
//
// Ports:
//   clk      in   system clock, rising-edge
//   reset    in   asynchronous active-high reset
//   f_pc     in   [31:0] PC of the fetched instruction
//   f_instr  in   [31:0] instruction word read at f_pc
//   f_valid  in   fetch pair valid this cycle
//   f_stall  out  hold the PC register (queue full)
//   flush    in   redirect; drops queued and incoming entries
//   d_pc     out  [31:0] PC of the head entry (0 when empty)
//   d_instr  out  [31:0] instruction of the head entry (0 when empty)
//   d_valid  out  head entry present
//   d_ready  in   decode accepts the head entry this cycle
//   count    out  [PTR_W:0] occupancy, 0..DEPTH

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_instr,
  input  logic             f_valid,
  output logic             f_stall,
  input  logic             flush,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_instr,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [63:0]      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // Derived from the registered count only, so decode's d_ready can never
  // reach the PC register combinationally.
  assign f_stall = full;
  assign head    = mem[rp];

  // A storage pop needs a real stored entry; a bypassed pair never counts.
  assign pop = !empty && d_ready && !flush;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  logic bypass_take;

  assign bypass      = empty && f_valid && !flush;
  assign bypass_take = bypass && d_ready;
  // A pair consumed through the bypass is never written into storage.
  assign push        = f_valid && !full && !flush && !bypass_take;

  always_comb begin
    d_valid = 1'b0;
    d_pc    = '0;
    d_instr = '0;
    if (!empty) begin
      d_valid = 1'b1;
      d_pc    = head[63:32];
      d_instr = head[31:0];
    end else if (bypass) begin
      d_valid = 1'b1;
      d_pc    = f_pc;
      d_instr = f_instr;
    end
  end
`else
  // A full queue refuses the push even if a pop frees a slot this cycle.
  assign push = f_valid && !full && !flush;

  always_comb begin
    d_valid = 1'b0;
    d_pc    = '0;
    d_instr = '0;
    if (!empty) begin
      d_valid = 1'b1;
      d_pc    = head[63:32];
      d_instr = head[31:0];
    end
  end
`endif

  // Pointer, occupancy and storage update. Flush wins over push and pop and
  // leaves the stale entry contents in place; they are unreachable once the
  // count is zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {f_pc, f_instr};
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (default
// build, FETCHQ_BYPASS_EN undefined). Inputs change 1ns after each rising
// edge; outputs are sampled a further 1ns later, well away from the edge.

module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_stall;
  logic        flush;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  count;

  int checks;
  int errors;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .f_valid (f_valid),
    .f_stall (f_stall),
    .flush   (flush),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tied to its PC so a d_instr mix-up is detectable.
  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return ~pc ^ 32'h0000_0013;
  endfunction

  task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                               input logic fl, input logic dr);
    f_valid = fv;
    f_pc    = pc;
    f_instr = instrOf(pc);
    flush   = fl;
    d_ready = dr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    f_valid = 1'b0;
    f_pc    = '0;
    f_instr = '0;
    flush   = 1'b0;
    d_ready = 1'b0;

    // Reset state
    tick();
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_dvalid", 32'(d_valid), 32'd0);
    checkOutput("rst_stall", 32'(f_stall), 32'd0);
    checkOutput("rst_dpc", d_pc, 32'h0);
    checkOutput("rst_dinstr", d_instr, 32'h0);
    reset = 1'b0;
    tick();

    // Build up three entries, then reset asynchronously between edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_dvalid", 32'(d_valid), 32'd0);
    checkOutput("async_rst_stall", 32'(f_stall), 32'd0);
    checkOutput("async_rst_dpc", d_pc, 32'h0);
    #1;
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0);
    checkOutput("lat_not_yet", 32'(d_valid), 32'd0);
    tick();
    checkOutput("post_rst_dpc", d_pc, 32'h3000);
    checkOutput("post_rst_dinstr", d_instr, instrOf(32'h3000));
    checkOutput("post_rst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("drain1_count", 32'(count), 32'd0);

    // Fill to full, hold a fifth pair, free a slot
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_stall", 32'(f_stall), 32'd1);
    checkOutput("full_dpc", d_pc, 32'h3000);
    applyStimulus(1'b1, 32'h3010, 1'b0, 1'b0);
    tick();
    checkOutput("full_hold_count", 32'(count), 32'd4);
    checkOutput("full_hold_stall", 32'(f_stall), 32'd1);
    // Full with pop and push together: push refused, head popped
    applyStimulus(1'b1, 32'h3010, 1'b0, 1'b1);
    tick();
    checkOutput("full_poppush_count", 32'(count), 32'd3);
    checkOutput("full_poppush_stall", 32'(f_stall), 32'd0);
    checkOutput("full_poppush_dpc", d_pc, 32'h3004);
    applyStimulus(1'b1, 32'h3010, 1'b0, 1'b0);
    tick();
    checkOutput("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drain_dpc", d_pc, 32'h3004 + 32'(4 * i));
      checkOutput("drain_dinstr", d_instr, instrOf(32'h3004 + 32'(4 * i)));
      tick();
    end
    checkOutput("drained_count", 32'(count), 32'd0);
    checkOutput("drained_dvalid", 32'(d_valid), 32'd0);
    checkOutput("drained_dpc", d_pc, 32'h0);

    // Continuous stream of ten pairs with d_ready held high
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(i < 10, 32'h3000 + 32'(4 * i), 1'b0, 1'b1);
      if (i > 0) begin
        checkOutput("stream_dpc", d_pc, 32'h3000 + 32'(4 * (i - 1)));
        checkOutput("stream_dvalid", 32'(d_valid), 32'd1);
      end
      tick();
      if (i < 10) checkOutput("stream_count", 32'(count), 32'd1);
    end
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Flush with incoming pair and d_ready both asserted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("preflush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 32'h3040, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_dvalid", 32'(d_valid), 32'd0);
    checkOutput("flush_stall", 32'(f_stall), 32'd0);
    applyStimulus(1'b1, 32'h3080, 1'b0, 1'b0);
    tick();
    checkOutput("postflush_dpc", d_pc, 32'h3080);
    checkOutput("postflush_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("postflush_drain", 32'(count), 32'd0);

    // d_ready while empty must not move the read pointer
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("idle_ready_count", 32'(count), 32'd0);
    end
    checkOutput("idle_ready_dvalid", 32'(d_valid), 32'd0);
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0);
    tick();
    checkOutput("idle_after_dpc", d_pc, 32'h3000);
    checkOutput("idle_after_dinstr", d_instr, instrOf(32'h3000));
    checkOutput("idle_after_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("idle_second_dpc", d_pc, 32'h3004);
    tick();
    checkOutput("idle_final_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
